// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding and width helpers for the INTA sequencer.
package pic_pkg;

    localparam int VEC_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        INTA1,
        GAP,
        INTA2,
        RECOVER
    } pic_state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pic_inta_seq.sv
// pic_inta_seq: two-pulse INTA sequencer between the 8259-style controller and the CPU.
// Optional GAP timeout via `define PIC_INTA_TIMEOUT_EN.
module pic_inta_seq
    import pic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             interrupt_do,
    input  logic [VEC_W-1:0] interrupt_vector,
    input  logic             cpu_inta,
    output logic             cpu_intr,
    output logic             inta_data_oe,
    output logic [VEC_W-1:0] inta_data,
    output logic             interrupt_done,
    output logic             inta_timeout
);

    localparam int RW = cnt_w(RECOVER_CYCLES);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pic_inta_seq: TIMEOUT_CYCLES must be at least 1");
    end

    pic_state_t       state, state_n;
    logic             inta_last;
    logic             rise, fall;
    logic             intr_n, oe_n, done_n;
    logic [VEC_W-1:0] data_n;
    logic [RW-1:0]    rcv_cnt, rcv_n;

    assign rise = cpu_inta & ~inta_last;
    assign fall = ~cpu_inta & inta_last;

`ifdef PIC_INTA_TIMEOUT_EN
    localparam int GW = cnt_w(TIMEOUT_CYCLES);
    logic [GW-1:0] gap_cnt, gap_n;
    logic          tmo_n;
`else
    assign inta_timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        intr_n  = 1'b0;
        oe_n    = 1'b0;
        done_n  = 1'b0;
        data_n  = inta_data;
        rcv_n   = rcv_cnt;
`ifdef PIC_INTA_TIMEOUT_EN
        gap_n   = gap_cnt;
        tmo_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                intr_n = interrupt_do;
                if (rise) begin
                    data_n  = interrupt_vector;
                    intr_n  = 1'b0;
                    state_n = INTA1;
                end
            end
            INTA1: begin
                if (fall) begin
`ifdef PIC_INTA_TIMEOUT_EN
                    gap_n   = '0;
`endif
                    state_n = GAP;
                end
            end
            GAP: begin
                if (rise) begin
                    oe_n    = 1'b1;
                    state_n = INTA2;
                end
`ifdef PIC_INTA_TIMEOUT_EN
                else begin
                    gap_n = gap_cnt + 1'b1;
                    // abandon the pair but still ack so the controller drops its request
                    if (gap_n == GW'(TIMEOUT_CYCLES)) begin
                        tmo_n   = 1'b1;
                        done_n  = 1'b1;
                        rcv_n   = RW'(RECOVER_CYCLES);
                        state_n = RECOVER;
                    end
                end
`endif
            end
            INTA2: begin
                oe_n = 1'b1;
                if (fall) begin
                    oe_n    = 1'b0;
                    done_n  = 1'b1;
                    rcv_n   = RW'(RECOVER_CYCLES);
                    state_n = RECOVER;
                end
            end
            RECOVER: begin
                rcv_n   = (rcv_cnt == '0) ? '0 : rcv_cnt - 1'b1;
                state_n = (rcv_cnt <= RW'(1)) ? IDLE : RECOVER;
            end
            default: state_n = IDLE;
        endcase
    end

    // inta_last resets high so an INTA already active at release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            inta_last      <= 1'b1;
            cpu_intr       <= 1'b0;
            inta_data_oe   <= 1'b0;
            inta_data      <= '0;
            interrupt_done <= 1'b0;
            rcv_cnt        <= '0;
`ifdef PIC_INTA_TIMEOUT_EN
            gap_cnt        <= '0;
            inta_timeout   <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            inta_last      <= cpu_inta;
            cpu_intr       <= intr_n;
            inta_data_oe   <= oe_n;
            inta_data      <= data_n;
            interrupt_done <= done_n;
            rcv_cnt        <= rcv_n;
`ifdef PIC_INTA_TIMEOUT_EN
            gap_cnt        <= gap_n;
            inta_timeout   <= tmo_n;
`endif
        end
    end

endmodule

// File: tb/tb_pic_inta_seq.sv
// tb_pic_inta_seq: directed bench for pic_inta_seq; vectors are queued at INTA1 and
// popped against inta_data on every interrupt_done pulse.
module tb_pic_inta_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       interrupt_do = 1'b0;
    logic [7:0] interrupt_vector = 8'h00;
    logic       cpu_inta = 1'b0;
    logic       cpu_intr, inta_data_oe, interrupt_done, inta_timeout;
    logic [7:0] inta_data;

    int         errors = 0;
    int         checks = 0;
    int         dones = 0;
    int         d0;
    logic       prev_done = 1'b0;
    logic [7:0] sb[$];

    pic_inta_seq #(.TIMEOUT_CYCLES(8), .RECOVER_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .interrupt_do(interrupt_do),
        .interrupt_vector(interrupt_vector),
        .cpu_inta(cpu_inta),
        .cpu_intr(cpu_intr),
        .inta_data_oe(inta_data_oe),
        .inta_data(inta_data),
        .interrupt_done(interrupt_done),
        .inta_timeout(inta_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (interrupt_done) begin
            dones++;
            chk("done_not_back_to_back", 8'(prev_done), 8'h0);
            chk("done_expected", 8'(sb.size() != 0), 8'h1);
            if (sb.size() != 0) chk("done_vector", inta_data, sb.pop_front());
        end
        prev_done = interrupt_done;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic seq(input logic [7:0] v, input int n1, input int ng, input int n2);
        int c;
        interrupt_vector = v;
        sb.push_back(v);
        cpu_inta = 1'b1;
        ticks(n1);
        chk("inta1_intr", 8'(cpu_intr), 8'h0);
        cpu_inta = 1'b0;
        for (int i = 0; i < ng; i++) begin
            tick();
            chk("gap_oe", 8'(inta_data_oe), 8'h0);
        end
        cpu_inta = 1'b1;
        for (int i = 0; i < n2; i++) begin
            tick();
            chk("inta2_oe", 8'(inta_data_oe), 8'h1);
            chk("inta2_data", inta_data, v);
        end
        cpu_inta = 1'b0;
        c = dones;
        tick();
        chk("seq_done", 8'(interrupt_done), 8'h1);
        chk("seq_done_count", 8'(dones - c), 8'h1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_intr", 8'(cpu_intr), 8'h0);
        chk("rst_oe", 8'(inta_data_oe), 8'h0);
        chk("rst_data", inta_data, 8'h00);
        chk("rst_done", 8'(interrupt_done), 8'h0);
        chk("rst_tmo", 8'(inta_timeout), 8'h0);
        rst_n = 1'b1;
        ticks(2);
        // basic sequence with vector change in the gap
        interrupt_do = 1'b1;
        interrupt_vector = 8'h72;
        tick();
        chk("idle_intr", 8'(cpu_intr), 8'h1);
        sb.push_back(8'h72);
        cpu_inta = 1'b1;
        tick();
        chk("intr_drop", 8'(cpu_intr), 8'h0);
        chk("inta1_oe", 8'(inta_data_oe), 8'h0);
        ticks(2);
        cpu_inta = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("basic_gap_oe", 8'(inta_data_oe), 8'h0);
            chk("basic_gap_intr", 8'(cpu_intr), 8'h0);
            if (i == 1) interrupt_vector = 8'h75;
        end
        cpu_inta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("basic_oe", 8'(inta_data_oe), 8'h1);
            chk("freeze_data", inta_data, 8'h72);
        end
        cpu_inta = 1'b0;
        d0 = dones;
        tick();
        chk("basic_done", 8'(interrupt_done), 8'h1);
        chk("basic_oe_drop", 8'(inta_data_oe), 8'h0);
        chk("basic_done_count", 8'(dones - d0), 8'h1);
        tick();
        chk("done_one_clock", 8'(interrupt_done), 8'h0);
        chk("recover_intr1", 8'(cpu_intr), 8'h0);
        tick();
        chk("recover_intr2", 8'(cpu_intr), 8'h0);
        tick();
        chk("b2b_intr_reassert", 8'(cpu_intr), 8'h1);
        interrupt_do = 1'b0;
        ticks(2);
        chk("intr_follow_do", 8'(cpu_intr), 8'h0);
        // spurious, then a rise during RECOVER that must be ignored
        seq(8'h77, 2, 2, 2);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        d0 = dones;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("recover_rise_oe", 8'(inta_data_oe), 8'h0);
        end
        chk("recover_rise_no_done", 8'(dones - d0), 8'h0);
        // lost second INTA
        interrupt_do = 1'b1;
        interrupt_vector = 8'h5A;
        tick();
        sb.push_back(8'h5A);
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        tick();
`ifdef PIC_INTA_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tmo_early", 8'(inta_timeout), 8'h0);
            chk("tmo_done_early", 8'(interrupt_done), 8'h0);
        end
        tick();
        chk("tmo_pulse", 8'(inta_timeout), 8'h1);
        chk("tmo_done", 8'(interrupt_done), 8'h1);
        tick();
        chk("tmo_one_clock", 8'(inta_timeout), 8'h0);
        chk("tmo_done_one_clock", 8'(interrupt_done), 8'h0);
`else
        d0 = dones;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("gap_wait_tmo", 8'(inta_timeout), 8'h0);
            chk("gap_wait_oe", 8'(inta_data_oe), 8'h0);
        end
        chk("gap_wait_no_done", 8'(dones - d0), 8'h0);
        cpu_inta = 1'b1;
        tick();
        chk("late_inta2_oe", 8'(inta_data_oe), 8'h1);
        chk("late_inta2_data", inta_data, 8'h5A);
        cpu_inta = 1'b0;
        tick();
        chk("late_done", 8'(interrupt_done), 8'h1);
`endif
        ticks(3);
        // reset during INTA2 with INTA held through release
        interrupt_vector = 8'h33;
        tick();
        cpu_inta = 1'b1;
        tick();
        cpu_inta = 1'b0;
        tick();
        cpu_inta = 1'b1;
        tick();
        chk("pre_rst_oe", 8'(inta_data_oe), 8'h1);
        chk("pre_rst_data", inta_data, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", 8'(inta_data_oe), 8'h0);
        chk("async_rst_data", inta_data, 8'h00);
        chk("async_rst_intr", 8'(cpu_intr), 8'h0);
        d0 = dones;
        ticks(2);
        rst_n = 1'b1;
        tick();
        chk("rel_no_seq_intr", 8'(cpu_intr), 8'h1);
        chk("rel_no_seq_oe", 8'(inta_data_oe), 8'h0);
        cpu_inta = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rel_idle_intr", 8'(cpu_intr), 8'h1);
        end
        chk("rst_no_done", 8'(dones - d0), 8'h0);
        // normal operation after reset
        seq(8'hA5, 1, 3, 1);
        ticks(3);
        chk("sb_drained", 8'(sb.size()), 8'h0);
        chk("total_dones", 8'(dones), 8'h4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_inta_seq.md
Name: pic_inta_seq

Overview:
- CPU-side interrupt acknowledge sequencer, directly downstream of the 8259-style interrupt controller.
- Turns the controller's interrupt_do / interrupt_vector into the CPU INTR level.
- Tracks the two-pulse 8086/V30 INTA bus cycle, drives the vector byte during the second INTA and returns a one-cycle interrupt_done pulse to the controller.
- Also guards against a lost second INTA.

Parameters:
- TIMEOUT_CYCLES, 255: maximum clocks allowed between end of INTA1 and start of INTA2 (only with the optional feature); counter width = $clog2(TIMEOUT_CYCLES+1).
- RECOVER_CYCLES, 2: clocks cpu_intr is forced low after interrupt_done, covering the controller's registered interrupt_do drop.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- interrupt_do  in  1  controller request level
- interrupt_vector  in  8  controller vector, valid while interrupt_do=1
- cpu_inta  in  1  decoded CPU INTA bus-cycle level, high for 1+ clocks per INTA
- cpu_intr  out  1  INTR level to CPU
- inta_data_oe  out  1  high while the vector must be driven onto the CPU data bus
- inta_data  out  8  latched vector byte
- interrupt_done  out  1  one-clock acknowledge pulse to the controller
- inta_timeout  out  1  one-clock pulse when a sequence is abandoned (0 when feature is off)

Behaviour:
- Reset (async, rst_n=0) values:
  - cpu_intr=0, inta_data_oe=0, inta_data=8'h00, interrupt_done=0, inta_timeout=0.
  - state=IDLE, inta_last=1, so an INTA already high at reset release is not an edge.
  - Counters are 0.
- Edge detection:
  - inta_last <= cpu_inta every clock.
  - rise = cpu_inta & ~inta_last; fall = ~cpu_inta & inta_last.
  - All state transitions are registered; response latency is 1 clock after the sampled edge.
- States: IDLE, INTA1, GAP, INTA2, RECOVER.
- IDLE:
  - cpu_intr <= interrupt_do.
  - On rise: inta_data <= interrupt_vector (vector frozen at INTA1), cpu_intr <= 0, go to INTA1.
  - A rise with interrupt_do=0 (spurious) is still sequenced with whatever vector is present.
- INTA1: cpu_intr=0. On fall, clear the gap counter and go to GAP.
- GAP:
  - On rise: inta_data_oe <= 1, go to INTA2.
  - Otherwise, with the feature enabled, increment the gap counter; at TIMEOUT_CYCLES pulse inta_timeout, pulse interrupt_done (the controller must not stay pending), and go to RECOVER.
- INTA2:
  - inta_data_oe=1 and inta_data is stable for the whole state.
  - On fall: inta_data_oe <= 0, interrupt_done <= 1 for exactly one clock, load the recover counter, go to RECOVER.
- RECOVER:
  - cpu_intr=0. Decrement the counter; at 0 go to IDLE.
  - Rising edges seen in RECOVER are ignored.
- interrupt_vector changes after INTA1 never affect inta_data.
- interrupt_done is never asserted in consecutive clocks.
- Reset mid-sequence clears everything immediately: inta_data_oe drops asynchronously and no done pulse is issued.

Optional Feature:
- Macro PIC_INTA_TIMEOUT_EN.
- Defined: the GAP timeout counter and inta_timeout pulse exist as described.
- Undefined: the counter is removed, GAP waits indefinitely for INTA2, and inta_timeout is tied to 0.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum (IDLE/INTA1/GAP/INTA2/RECOVER);
  - the localparam widths for the vector (8) and the counters.
- No sub-module: the edge detector and counters are inline.

Test Plan:
- Basic sequence:
  - Stimulus: interrupt_do=1, vector=8'h72; INTA1 for 3 clocks, gap 4, INTA2 for 3 clocks.
  - Required response: cpu_intr high until 1 clock after INTA1 rise; inta_data_oe high only during INTA2 with inta_data=8'h72; exactly one done pulse 1 clock after INTA2 fall; cpu_intr low for 2 RECOVER clocks.
- Vector freeze:
  - Stimulus: vector changes 8'h72 -> 8'h75 between INTA1 and INTA2.
  - Required response: inta_data stays 8'h72.
- Spurious:
  - Stimulus: interrupt_do=0, vector=8'h77, full INTA pair.
  - Required response: sequence completes, 8'h77 is driven, done pulses once.
- Timeout (feature on, TIMEOUT_CYCLES=8):
  - Stimulus: INTA1 only.
  - Required response: 8 clocks after INTA1 fall, inta_timeout and interrupt_done pulse together, then IDLE; with the feature off, the block stays in GAP.
- Reset:
  - Stimulus: rst_n low during INTA2.
  - Required response: inta_data_oe=0 asynchronously, no done pulse; cpu_inta held high through reset release causes no sequence.
- Back-to-back:
  - Stimulus: interrupt_do stays high after done.
  - Required response: cpu_intr reasserts no earlier than RECOVER_CYCLES+1 clocks after the done pulse.
